mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter WIDTH, default 8, memory word width in bits; SHALL be a multiple of 8 (BYTES = WIDTH/8).
REQ-002 Parameter DEPTH, default 8, number of words to load; AW = $clog2(DEPTH).
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begins a load session when sampled high in IDLE.
REQ-006 abort  input  1  synchronous cancel of the current session.
REQ-007 in_valid  input  1  byte-stream valid.
REQ-008 in_data  input  8  byte-stream data.
REQ-009 in_ready  output  1  byte-stream ready.
REQ-010 wr_en  output  1  memory write strobe, one-cycle pulse per word.
REQ-011 wr_addr  output  AW  memory write address.
REQ-012 wr_data  output  WIDTH  memory write data.
REQ-013 busy  output  1  high while in LOAD.
REQ-014 done  output  1  one-cycle pulse after the final word has been written.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, LOAD and DONE.
REQ-016 IDLE -> LOAD when start=1 and abort=0; in the same edge, address counter <= 0 and byte counter <= 0.
REQ-017 in_ready SHALL be combinational and equal (state==LOAD); busy SHALL equal (state==LOAD).
REQ-018 A byte is accepted on a posedge where in_valid=1 and in_ready=1; in_data SHALL not be sampled otherwise.
REQ-019 Byte packing SHALL be little-endian: the k-th accepted byte of a word (k=0..BYTES-1) lands in bits [8k+7:8k].
REQ-020 On the edge accepting byte BYTES-1, the block SHALL register wr_en<=1, wr_data<=assembled word, wr_addr<=address counter, then increment the address counter and clear the byte counter.
REQ-021 Write latency: wr_en SHALL be high in exactly the cycle following the accepting edge of a word's last byte; low in all other cycles.
REQ-022 wr_addr and wr_data SHALL hold their last written values when wr_en=0.
REQ-023 When the written word's address is DEPTH-1, the same edge SHALL move the FSM LOAD -> DONE (no address wrap to 0 within a session).
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done=0 in all other states.
REQ-025 start SHALL be ignored in LOAD and DONE.
REQ-026 abort=1 in LOAD SHALL, on that edge, return the FSM to IDLE, discard any partial word, and not generate wr_en or done; a byte presented with abort=1 SHALL not be written.
REQ-027 abort SHALL have priority over start, in_valid and the LOAD->DONE transition; abort in IDLE or DONE SHALL force IDLE with no other effect.
REQ-028 in_valid with in_ready=0 SHALL have no effect; gaps in in_valid SHALL not lose or reorder bytes.

Reset
REQ-029 While rst_n=0: state=IDLE, address counter=0, byte counter=0, wr_en=0, wr_addr=0, wr_data=0, done=0, busy=0, in_ready=0.
REQ-030 Assertion of rst_n mid-session SHALL immediately abandon the session; no write SHALL occur from partial data after release.
REQ-031 After rst_n release, the block SHALL stay in IDLE until start is sampled.

Verification
REQ-032 WIDTH=8, DEPTH=4, start then bytes 11,22,33,44 back-to-back -> wr_en pulses at addr 0..3 with data 11,22,33,44, each one cycle after acceptance; done pulses once the cycle after the addr-3 write; busy falls with it.
REQ-033 WIDTH=16, DEPTH=2, bytes 34,12,78,56 with in_valid low for 2 cycles between each -> writes 0x1234 @0, 0x5678 @1; no extra wr_en pulses.
REQ-034 WIDTH=16, DEPTH=4, send 3 bytes then abort=1 with in_valid=1 -> one write (addr 0), no further wr_en, no done, state IDLE; new start then 2 bytes -> write at addr 0.
REQ-035 Assert rst_n low after 1 byte of a 16-bit word -> all outputs 0 immediately; after release and a new session, first write at addr 0 contains only new bytes.
REQ-036 start held high continuously across a full DEPTH=4 session -> exactly one session runs; after DONE->IDLE, next start edge begins a new session at addr 0.
REQ-037 in_valid=1 while IDLE or DONE -> in_ready=0, no byte accepted, no wr_en.

Source files
------------

// File: rtl/mem_loader.sv
// Packs a little-endian byte stream into WIDTH-bit words and writes DEPTH of them per session.
// wr_en follows a word's last accepted byte by one cycle; in_ready is high only in LOAD, and abort cancels the session without writing.
module mem_loader #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int BYTES = WIDTH / 8,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             wr_en,
   output logic [AW-1:0]    wr_addr,
   output logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [AW-1:0]    r_addr;
   logic [BCW-1:0]   r_bcnt;
   logic [WIDTH-1:0] r_word;
   logic [WIDTH-1:0] w_word;
   logic             w_start;
   logic             w_accept;
   logic             w_last_byte;
   logic             w_last_word;

   assign in_ready    = (r_state == S_LOAD);
   assign busy        = (r_state == S_LOAD);
   assign done        = (r_state == S_DONE);
   assign w_start     = (r_state == S_IDLE) && start && !abort;
   assign w_accept    = in_ready && in_valid && !abort;
   assign w_last_byte = (r_bcnt == BCW'(BYTES - 1));
   assign w_last_word = (r_addr == AW'(DEPTH - 1));

   // Current partial word with the incoming byte dropped into its little-endian lane
   always_comb begin
      w_word = r_word;
      for (int k = 0; k < BYTES; k++) begin
         if (r_bcnt == BCW'(k)) begin
            w_word[8*k +: 8] = in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else if (w_accept && w_last_byte && w_last_word) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_bcnt  <= '0;
         r_word  <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= 1'b0;
         if (w_start) begin
            r_addr <= '0;
            r_bcnt <= '0;
         end else if (in_ready && abort) begin
            r_bcnt <= '0;
         end else if (w_accept) begin
            if (w_last_byte) begin
               wr_en   <= 1'b1;
               wr_data <= w_word;
               wr_addr <= r_addr;
               r_addr  <= r_addr + AW'(1);
               r_bcnt  <= '0;
            end else begin
               r_word <= w_word;
               r_bcnt <= r_bcnt + BCW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: a byte-queue reference model predicts writes and done pulses,
// and a negedge monitor compares them against the DUT through a scoreboard.
module tb_mem_loader;
   localparam int WIDTH  = 16;
   localparam int DEPTH  = 4;
   localparam int BYTES  = WIDTH / 8;
   localparam int AW     = $clog2(DEPTH);
   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_DONE = 2;

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b0;
   logic             start    = 1'b0;
   logic             abort    = 1'b0;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data  = 8'h00;
   logic             in_ready;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             busy;
   logic             done;

   always #5 clk = ~clk;

   mem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done)
   );

   typedef struct {
      int               cyc;
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
   } wr_t;

   wr_t              exp_q[$];
   int               done_q[$];
   int               n_cmp = 0;
   int               n_bad = 0;
   int               cyc   = 0;
   int               m_phase = P_IDLE;
   int               m_addr  = 0;
   logic [7:0]       m_bytes[$];
   logic [AW-1:0]    hold_addr = '0;
   logic [WIDTH-1:0] hold_data = '0;
   bit               mon_ew;
   bit               mon_ed;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Session-level model: collect accepted bytes, emit a word every BYTES of them
   task automatic model_edge(input bit s, input bit a, input bit v, input logic [7:0] d);
      logic [WIDTH-1:0] w;
      wr_t              e;
      case (m_phase)
         P_IDLE: begin
            if (s && !a) begin
               m_phase = P_LOAD;
               m_addr  = 0;
               m_bytes.delete();
            end
         end
         P_LOAD: begin
            if (a) begin
               m_phase = P_IDLE;
               m_bytes.delete();
            end else if (v) begin
               m_bytes.push_back(d);
               if (m_bytes.size() == BYTES) begin
                  w = '0;
                  for (int k = 0; k < BYTES; k++) w = w + (WIDTH'(m_bytes[k]) << (8 * k));
                  e.cyc  = cyc + 1;
                  e.addr = AW'(m_addr);
                  e.data = w;
                  exp_q.push_back(e);
                  m_bytes.delete();
                  if (m_addr == DEPTH - 1) begin
                     m_phase = P_DONE;
                     done_q.push_back(cyc + 1);
                  end
                  m_addr++;
               end
            end
         end
         default: m_phase = P_IDLE;
      endcase
   endtask

   task automatic step(input bit s, input bit a, input bit v, input logic [7:0] d);
      chk("in_ready", in_ready, (m_phase == P_LOAD));
      chk("busy", busy, (m_phase == P_LOAD));
      start    = s;
      abort    = a;
      in_valid = v;
      in_data  = d;
      model_edge(s, a, v, d);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk);
      #1;
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst wr_en", wr_en, 0);
      chk("rst wr_addr", wr_addr, 0);
      chk("rst wr_data", wr_data, 0);
      chk("rst done", done, 0);
      chk("rst busy", busy, 0);
      chk("rst in_ready", in_ready, 0);
      m_phase = P_IDLE;
      m_bytes.delete();
      hold_addr = '0;
      hold_data = '0;
      repeat (hold) @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      mon_ew = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      mon_ed = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("wr_en", wr_en, mon_ew);
      chk("done", done, mon_ed);
      if (mon_ew) begin
         hold_addr = exp_q[0].addr;
         hold_data = exp_q[0].data;
         void'(exp_q.pop_front());
      end
      chk("wr_addr", wr_addr, hold_addr);
      chk("wr_data", wr_data, hold_data);
      if (mon_ed) void'(done_q.pop_front());
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      while (done_q.size() > 0 && done_q[0] < cyc) void'(done_q.pop_front());
   end

   initial begin
      do_reset(2);
      // idle with in_valid: nothing accepted
      repeat (3) step(0, 0, 1, 8'($urandom));

      // back-to-back session
      step(1, 0, 0, 8'h00);
      for (int i = 0; i < DEPTH * BYTES; i++) step(0, 0, 1, 8'($urandom));
      repeat (3) step(0, 0, 1, 8'($urandom));

      // gaps of two idle cycles between bytes
      step(1, 0, 0, 8'h00);
      for (int i = 0; i < DEPTH * BYTES; i++) begin
         step(0, 0, 1, 8'($urandom));
         repeat (2) step(0, 0, 0, 8'($urandom));
      end
      repeat (2) step(0, 0, 0, 8'h00);

      // abort with a byte presented, then a fresh session
      step(1, 0, 0, 8'h00);
      repeat (3) step(0, 0, 1, 8'($urandom));
      step(0, 1, 1, 8'hAA);
      repeat (2) step(0, 0, 1, 8'($urandom));
      step(1, 0, 0, 8'h00);
      repeat (2) step(0, 0, 1, 8'($urandom));
      step(0, 1, 0, 8'h00);
      repeat (2) step(0, 0, 0, 8'h00);

      // reset mid-word, then a full session from fresh bytes
      step(1, 0, 0, 8'h00);
      step(0, 0, 1, 8'h5A);
      do_reset(2);
      step(1, 0, 0, 8'h00);
      for (int i = 0; i < DEPTH * BYTES; i++) step(0, 0, 1, 8'($urandom));
      repeat (2) step(0, 0, 0, 8'h00);

      // start held high across sessions
      for (int i = 0; i < 3 * (DEPTH * BYTES + 3); i++) step(1, 0, 1, 8'($urandom));
      repeat (3) step(0, 0, 0, 8'h00);

      // randomized traffic with occasional aborts and resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset($urandom_range(1, 3));
         end else begin
            step(($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) != 0), 8'($urandom));
         end
      end
      repeat (4) step(0, 0, 0, 8'h00);

      chk("leftover writes", exp_q.size(), 0);
      chk("leftover done", done_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
